matmul_arbiter: RTL and testbench

MATMUL_ARBITER -- requirements
Module: matmul_arbiter

---
 rtl/matmul_pkg.sv | 15 +
 rtl/matmul_arbiter_if.sv | 54 +++++
 rtl/rr_arb2.sv | 14 +
 rtl/matmul_arbiter.sv | 133 +++++++++++++
 tb/tb_matmul_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared widths, defaults and FSM state type for the matmul arbiter
package matmul_pkg;

    localparam int ELEM_W                 = 32;
    localparam int MAT_W                  = 4 * ELEM_W;
    localparam int TIMEOUT_CYCLES_DEFAULT = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DELIVER
    } arb_state_t;

endpackage

// File: rtl/matmul_arbiter_if.sv
// rtl/matmul_arbiter_if.sv - requester, response and multiplier signals of the arbiter (rsp err with MATMUL_TIMEOUT_EN)
interface matmul_arbiter_if;
    import matmul_pkg::*;

    logic             req0_valid;
    logic             req0_ready;
    logic [MAT_W-1:0] req0_a;
    logic [MAT_W-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [MAT_W-1:0] req1_a;
    logic [MAT_W-1:0] req1_b;

    logic             rsp0_valid;
    logic             rsp0_ack;
    logic [MAT_W-1:0] rsp0_data;
    logic             rsp1_valid;
    logic             rsp1_ack;
    logic [MAT_W-1:0] rsp1_data;
`ifdef MATMUL_TIMEOUT_EN
    logic             rsp0_err;
    logic             rsp1_err;
`endif

    logic [MAT_W-1:0] mm_in1;
    logic [MAT_W-1:0] mm_in2;
    logic             mm_load;
    logic             mm_out_ack;
    logic [MAT_W-1:0] mm_out;
    logic             mm_out_ready;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        input  rsp0_ack, rsp1_ack, mm_out, mm_out_ready,
        output req0_ready, req1_ready, rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
`ifdef MATMUL_TIMEOUT_EN
        output rsp0_err, rsp1_err,
`endif
        output mm_in1, mm_in2, mm_load, mm_out_ack
    );

    // Requesters plus multiplier side
    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        output rsp0_ack, rsp1_ack, mm_out, mm_out_ready,
        input  req0_ready, req1_ready, rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
`ifdef MATMUL_TIMEOUT_EN
        input  rsp0_err, rsp1_err,
`endif
        input  mm_in1, mm_in2, mm_load, mm_out_ack
    );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant; the requester named by ptr wins a tie
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant    = 2'b00;
        grant[0] = valid[0] & (~ptr | ~valid[1]);
        grant[1] = valid[1] & ( ptr | ~valid[0]);
    end

endmodule

// File: rtl/matmul_arbiter.sv
// rtl/matmul_arbiter.sv - shares one 2x2 matrix multiplier between two requesters, one job at a time
// Optional MATMUL_TIMEOUT_EN: bounds the wait for mm_out_ready and flags the response with rspN_err.
module matmul_arbiter
    import matmul_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    matmul_arbiter_if.slave  bus
);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic             ptr;
    logic             gnt_id;
    logic [1:0]       gnt;
    logic             accept;
    logic             rsp_ack_g;
    logic [MAT_W-1:0] result;

    rr_arb2 u_rr_arb2 (
        .valid ({bus.req1_valid, bus.req0_valid}),
        .ptr   (ptr),
        .grant (gnt)
    );

    assign accept    = (state == ST_IDLE) && (|gnt);
    assign rsp_ack_g = gnt_id ? bus.rsp1_ack : bus.rsp0_ack;

`ifdef MATMUL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_fire;
    logic             err_q;

    // A result arriving in the last allowed cycle still wins over the timeout
    assign tmo_fire = (state == ST_RUN) && !bus.mm_out_ready &&
                      (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            tmo_cnt <= (state == ST_RUN && state_nxt == ST_RUN) ? tmo_cnt + 1'b1 : '0;
            if (accept) begin
                err_q <= 1'b0;
            end else if (tmo_fire) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.rsp0_err = bus.rsp0_valid & err_q;
    assign bus.rsp1_err = bus.rsp1_valid & err_q;
`endif

    always_comb begin
        state_nxt      = state;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.mm_load    = 1'b0;
        bus.mm_out_ack = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.req0_ready = gnt[0];
                bus.req1_ready = gnt[1];
                if (|gnt) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                bus.mm_load = 1'b1;
                if (bus.mm_out_ready) begin
                    state_nxt = ST_DRAIN;
                end
`ifdef MATMUL_TIMEOUT_EN
                else if (tmo_fire) begin
                    state_nxt = ST_DELIVER;
                end
`endif
            end
            ST_DRAIN: begin
                bus.mm_out_ack = 1'b1;
                state_nxt      = ST_DELIVER;
            end
            ST_DELIVER: begin
                if (rsp_ack_g) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            ptr        <= 1'b0;
            gnt_id     <= 1'b0;
            bus.mm_in1 <= '0;
            bus.mm_in2 <= '0;
            result     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                gnt_id     <= gnt[1];
                bus.mm_in1 <= gnt[1] ? bus.req1_a : bus.req0_a;
                bus.mm_in2 <= gnt[1] ? bus.req1_b : bus.req0_b;
            end
            if (state == ST_RUN && bus.mm_out_ready) begin
                result <= bus.mm_out;
            end
`ifdef MATMUL_TIMEOUT_EN
            else if (tmo_fire) begin
                result <= '0;
            end
`endif
            // The pointer moves only once a response has actually been consumed
            if (state == ST_DELIVER && rsp_ack_g) begin
                ptr <= ~gnt_id;
            end
        end
    end

    assign bus.rsp0_valid = (state == ST_DELIVER) && !gnt_id;
    assign bus.rsp1_valid = (state == ST_DELIVER) &&  gnt_id;
    assign bus.rsp0_data  = bus.rsp0_valid ? result : '0;
    assign bus.rsp1_data  = bus.rsp1_valid ? result : '0;

endmodule

// File: tb/tb_matmul_arbiter.sv
// tb/tb_matmul_arbiter.sv - randomized bench for matmul_arbiter against a queue-level model (MATMUL_TIMEOUT_EN aware)
module tb_matmul_arbiter;
    import matmul_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    matmul_arbiter_if bus ();

`ifdef MATMUL_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 64;
`endif

    matmul_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) ack_pulses <= ack_pulses + int'(bus.mm_out_ack);

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] f32_of_int(input int v);
        int e;
        logic [31:0] m;
        if (v == 0) return 32'h0;
        e = 0;
        for (int i = 0; i < 24; i++) if (v[i]) e = i;
        m = 32'(v) << (23 - e);
        return {1'b0, 8'(127 + e), m[22:0]};
    endfunction

    function automatic int int_of_f32(input logic [31:0] f);
        if (f[30:0] == 31'h0) return 0;
        return int'(32'({1'b1, f[22:0]}) >> (150 - 32'(f[30:23])));
    endfunction

    function automatic logic [127:0] pack(input int e [4]);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) r[32*k +: 32] = f32_of_int(e[k]);
        return r;
    endfunction

    // Reference product of [a0 a1; a2 a3] x [b0 b1; b2 b3]
    function automatic logic [127:0] ref_mul(input int a [4], input int b [4]);
        int c [4];
        c[0] = a[0]*b[0] + a[1]*b[2];
        c[1] = a[0]*b[1] + a[1]*b[3];
        c[2] = a[2]*b[0] + a[3]*b[2];
        c[3] = a[2]*b[1] + a[3]*b[3];
        return pack(c);
    endfunction

    function automatic logic [127:0] stub_mul(input logic [127:0] x, input logic [127:0] y);
        int a [4];
        int b [4];
        int c [4];
        for (int k = 0; k < 4; k++) begin
            a[k] = int_of_f32(x[32*k +: 32]);
            b[k] = int_of_f32(y[32*k +: 32]);
        end
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                c[2*i+j] = a[2*i]*b[j] + a[2*i+1]*b[2+j];
        return pack(c);
    endfunction

    // Multiplier stand-in: random latency, garbage ready pulses while not loaded
    int stub_lat = 0;
    int stub_cnt = 0;
    int last_lat = 0;
    bit stub_hold = 1'b0;
    initial begin
        bus.mm_out_ready = 1'b0;
        bus.mm_out       = '0;
        forever begin
            @(negedge clk);
            if (bus.mm_load === 1'b1) begin
                if (!stub_hold && stub_cnt == stub_lat) begin
                    bus.mm_out_ready = 1'b1;
                    bus.mm_out       = stub_mul(bus.mm_in1, bus.mm_in2);
                    last_lat         = stub_lat;
                end else begin
                    bus.mm_out_ready = 1'b0;
                    bus.mm_out       = {4{32'hDEADBEEF}};
                end
                stub_cnt++;
            end else begin
                stub_cnt         = 0;
                stub_lat         = $urandom_range(0, 4);
                bus.mm_out_ready = ($urandom_range(0, 3) == 0);
                bus.mm_out       = {4{32'hBAD0BAD0}};
            end
        end
    end

    bit             ptr_m = 1'b0;
    bit             pend [2];
    logic [127:0]   pa [2];
    logic [127:0]   pb [2];
    logic [127:0]   expd [2];
    int             last_g = -1;
    logic [127:0]   last_data = '0;

    function automatic bit rv(input int n);
        return (n == 0) ? bus.rsp0_valid : bus.rsp1_valid;
    endfunction

    function automatic logic [127:0] rdata(input int n);
        return (n == 0) ? bus.rsp0_data : bus.rsp1_data;
    endfunction

    task automatic set_req(input int n, input bit v);
        if (n == 0) begin
            bus.req0_valid = v; bus.req0_a = pa[0]; bus.req0_b = pb[0];
        end else begin
            bus.req1_valid = v; bus.req1_a = pa[1]; bus.req1_b = pb[1];
        end
    endtask

    task automatic set_ack(input int n, input bit v);
        if (n == 0) bus.rsp0_ack = v;
        else        bus.rsp1_ack = v;
    endtask

    task automatic load_req(input int n, input int a [4], input int b [4]);
        pa[n]   = pack(a);
        pb[n]   = pack(b);
        expd[n] = ref_mul(a, b);
        pend[n] = 1'b1;
        set_req(n, 1'b1);
    endtask

    task automatic new_req(input int n);
        int a [4];
        int b [4];
        for (int k = 0; k < 4; k++) begin
            a[k] = $urandom_range(0, 15);
            b[k] = $urandom_range(0, 15);
        end
        load_req(n, a, b);
    endtask

    // One full transaction for whichever requester the model says wins
    task automatic serve(input int ack_dly);
        int g;
        int t_acc;
        int p_acc;
        bit got;
        g   = pend[ptr_m] ? int'(ptr_m) : 1 - int'(ptr_m);
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            #1;
            if (bus.req0_ready | bus.req1_ready) begin got = 1'b1; break; end
            @(negedge clk);
        end
        if (!got) begin chk("grant_wait", 0, 1); return; end
        last_g = int'(bus.req1_ready);
        chk("grant_id", bus.req1_ready, g);
        chk("ready_excl", bus.req0_ready & bus.req1_ready, 0);
        t_acc = cyc;
        p_acc = ack_pulses;
        @(negedge clk);
        set_req(g, 1'b0);
        pend[g] = 1'b0;
        #1;
        chk("mm_load", bus.mm_load, 1);
        chk("mm_in1", bus.mm_in1, pa[g]);
        chk("mm_in2", bus.mm_in2, pb[g]);
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (rv(g)) begin got = 1'b1; break; end
            chk("busy_ready", {bus.req1_ready, bus.req0_ready}, 0);
            set_ack(0, $urandom_range(0, 1) == 1);
            set_ack(1, $urandom_range(0, 1) == 1);
            @(negedge clk);
            #1;
        end
        set_ack(0, 1'b0);
        set_ack(1, 1'b0);
        if (!got) begin chk("rsp_wait", 0, 1); return; end
        last_data = rdata(g);
        chk("latency", cyc - t_acc, 3 + last_lat);
        chk("out_ack_pulses", ack_pulses - p_acc, 1);
        chk("rsp_data", rdata(g), expd[g]);
        chk("rsp_other", rv(1 - g), 0);
`ifdef MATMUL_TIMEOUT_EN
        chk("rsp_err", (g == 0) ? bus.rsp0_err : bus.rsp1_err, 0);
`endif
        for (int i = 0; i < ack_dly; i++) begin
            @(negedge clk);
            #1;
            chk("hold_valid", rv(g), 1);
            chk("hold_data", rdata(g), expd[g]);
            chk("hold_ready", {bus.req1_ready, bus.req0_ready}, 0);
        end
        set_ack(g, 1'b1);
        @(negedge clk);
        set_ack(g, 1'b0);
        #1;
        chk("ack_drop", rv(g), 0);
        ptr_m = (g == 0);
    endtask

    initial begin
        int a1 [4];
        bit got;
        int t_load;
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a1 [4];
        bit got;
        int t_load;
        bus.req0_valid = 0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp0_ack = 0; bus.rsp1_ack = 0;
        pend[0] = 0; pend[1] = 0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", {bus.req1_ready, bus.req0_ready}, 0);
        chk("rst_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, 0);
        chk("rst_rsp_data", bus.rsp0_data | bus.rsp1_data, 0);
        chk("rst_mm_ctl", {bus.mm_load, bus.mm_out_ack}, 0);
        chk("rst_mm_in", bus.mm_in1 | bus.mm_in2, 0);
        @(negedge clk);
        rst = 1'b0;

        a1 = '{1, 2, 3, 4};
        load_req(0, a1, a1);
        serve(2);
        chk("known_product", last_data, 128'h41B00000_41700000_41200000_40E00000);

        // Pointer must return to 0 on reset even though it now points at req1
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ptr_m = 1'b0;
        new_req(0);
        new_req(1);
        serve(20);
        chk("order_first", last_g, 0);
        serve(0);
        chk("order_second", last_g, 1);
        new_req(0);
        new_req(1);
        serve(1);
        chk("order_third", last_g, 0);
        serve(0);

        for (int it = 0; it < 40; it++) begin
            for (int n = 0; n < 2; n++)
                if (!pend[n] && $urandom_range(0, 1) == 1) new_req(n);
            if (!pend[0] && !pend[1]) new_req($urandom_range(0, 1));
            serve($urandom_range(0, 4));
        end
        while (pend[0] || pend[1]) serve(0);

        // Reset in the middle of RUN
        stub_hold = 1'b1;
        new_req(0);
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (bus.req0_ready) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk("midrst_grant", got, 1);
        @(negedge clk);
        set_req(0, 1'b0);
        pend[0] = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_mm_load", bus.mm_load, 0);
        chk("midrst_mm_in", bus.mm_in1 | bus.mm_in2, 0);
        chk("midrst_rsp", {bus.rsp1_valid, bus.rsp0_valid}, 0);
        @(negedge clk);
        rst = 1'b0;
        stub_hold = 1'b0;
        ptr_m = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            chk("midrst_no_rsp", bus.rsp0_valid, 0);
        end
        new_req(1);
        serve(1);
        chk("midrst_next", last_g, 1);

`ifdef MATMUL_TIMEOUT_EN
        stub_hold = 1'b1;
        new_req(0);
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (bus.req0_ready) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk("tmo_grant", got, 1);
        @(negedge clk);
        set_req(0, 1'b0);
        pend[0] = 1'b0;
        #1;
        chk("tmo_load", bus.mm_load, 1);
        t_load = cyc;
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            #1;
            if (bus.rsp0_valid) begin got = 1'b1; break; end
        end
        chk("tmo_valid", got, 1);
        chk("tmo_latency", cyc - t_load, TMO);
        chk("tmo_data", bus.rsp0_data, 0);
        chk("tmo_err", bus.rsp0_err, 1);
        chk("tmo_load_low", bus.mm_load, 0);
        set_ack(0, 1'b1);
        @(negedge clk);
        set_ack(0, 1'b0);
        stub_hold = 1'b0;
        ptr_m = 1'b1;
        #1;
        chk("tmo_ack_drop", bus.rsp0_valid, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
